// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and constants for the sliced add/sub sequencer.
// Saturation limits are consumed only when ADD_SEQ_CTRL_SAT_EN is defined.
package add_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef logic req_id_t;

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/add_seq_rr_arb.sv
// add_seq_rr_arb: two-input round-robin arbiter.
// The pointer only flips on contention, so a lone requester never moves it.
module add_seq_rr_arb (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_valid,
    input  logic       i_adv,
    output logic [1:0] o_grant,
    output logic       o_ptr
);

    logic r_ptr;

    always_comb begin
        o_grant = (&i_valid) ? (r_ptr ? 2'b10 : 2'b01) : i_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_ptr <= 1'b0;
        else if (i_adv && (&i_valid))
            r_ptr <= ~r_ptr;
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: shares one 16-bit adder slice between two requesters, LSB slice first.
// Optional macro ADD_SEQ_CTRL_SAT_EN saturates res_sum on signed overflow.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_cout,
    output logic              res_ovf,
    output logic              res_id,
    output logic [15:0]       add_a,
    output logic [15:0]       add_b,
    output logic              add_cin,
    input  logic [15:0]       add_s,
    input  logic [15:0]       add_cout
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int KW     = $clog2(NSLICE);
    localparam int OW     = $clog2(DATA_W);

    state_t            r_state;
    state_t            w_next;
    logic [KW-1:0]     r_k;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_sum;
    logic              r_carry;
    logic              r_ovf;
    req_id_t           r_id;
    logic [1:0]        w_grant;
    logic              w_ptr;
    logic              w_idle;
    logic              w_go;
    logic              w_last;
    logic [OW-1:0]     w_off;
    logic              w_unused;

    add_seq_rr_arb u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid ({req1_valid, req0_valid}),
        .i_adv   (w_idle),
        .o_grant (w_grant),
        .o_ptr   (w_ptr)
    );

    assign w_idle     = r_state == IDLE;
    assign w_go       = w_idle && (|w_grant);
    assign w_last     = (r_state == RUN) && (r_k == KW'(NSLICE - 1));
    assign w_off      = {r_k, 4'b0000};
    assign req0_ready = w_idle & w_grant[0];
    assign req1_ready = w_idle & w_grant[1];
    assign w_unused   = ^{add_cout[SLICE_W-2:0], w_ptr};

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (r_state == RUN) begin
            add_a   = r_a[w_off +: SLICE_W];
            add_b   = r_b[w_off +: SLICE_W];
            add_cin = r_carry;
        end
        w_next = w_idle ? (w_go ? RUN : IDLE)
               : (r_state == RUN) ? (w_last ? DONE : RUN)
               : (res_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in as the first carry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_id    <= 1'b0;
        end else if (w_go) begin
            r_a     <= w_grant[1] ? req1_a : req0_a;
            r_b     <= w_grant[1] ? (req1_sub ? ~req1_b : req1_b) : (req0_sub ? ~req0_b : req0_b);
            r_carry <= w_grant[1] ? req1_sub : req0_sub;
            r_id    <= w_grant[1];
            r_k     <= '0;
        end else if (r_state == RUN) begin
            r_sum[w_off +: SLICE_W] <= add_s;
            r_carry                 <= add_cout[SLICE_W-1];
            r_k                     <= r_k + KW'(1);
            if (w_last)
                r_ovf <= (r_a[DATA_W-1] == r_b[DATA_W-1]) && (add_s[SLICE_W-1] != r_a[DATA_W-1]);
        end
    end

    assign res_valid = r_state == DONE;
    assign res_cout  = r_carry;
    assign res_ovf   = r_ovf;
    assign res_id    = r_id;

`ifdef ADD_SEQ_CTRL_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(sat_max(DATA_W));
    localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(sat_min(DATA_W));
    assign res_sum = r_ovf ? (r_a[DATA_W-1] ? SAT_MIN : SAT_MAX) : r_sum;
`else
    assign res_sum = r_sum;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: table-driven and scoreboard checks of add_seq_ctrl with a behavioural adder slice.
module tb_add_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_sub = 1'b0, req1_sub = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_sum;
    logic        res_cout, res_ovf, res_id;
    logic [15:0] add_a, add_b, add_s, add_cout;
    logic        add_cin;

    add_seq_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
        .res_ovf(res_ovf), .res_id(res_id),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [16:0] c;
        c     = '0;
        add_s = '0;
        c[0]  = add_cin;
        for (int i = 0; i < 16; i++) begin
            add_s[i] = add_a[i] ^ add_b[i] ^ c[i];
            c[i+1]   = (add_a[i] & add_b[i]) | (add_a[i] & c[i]) | (add_b[i] & c[i]);
        end
        add_cout = c[16:1];
    end

    typedef struct {
        bit          id;
        logic [31:0] sum;
        bit          cout;
        bit          ovf;
    } exp_t;

    typedef struct {
        bit          sel;
        logic [31:0] a;
        logic [31:0] b;
        bit          sub;
        logic [31:0] sum_wrap;
        logic [31:0] sum_sat;
        bit          cout;
        bit          ovf;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit id, input logic [31:0] a, input logic [31:0] b, input bit sub);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] s;
        bb     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
        e.id   = id;
        e.sum  = s[31:0];
        e.cout = s[32];
        e.ovf  = (a[31] == bb[31]) && (s[31] != a[31]);
`ifdef ADD_SEQ_CTRL_SAT_EN
        if (e.ovf) e.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_a, req0_b, req0_sub));
            if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, req1_sub));
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_result", 64'(res_sum), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_sum", 64'(res_sum), 64'(e.sum));
                    chk("sb_cout", 64'(res_cout), 64'(e.cout));
                    chk("sb_ovf", 64'(res_ovf), 64'(e.ovf));
                    chk("sb_id", 64'(res_id), 64'(e.id));
                end
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b, input bit sub, output exp_t got);
        bit ok;
        got = '{default: '0};
        if (sel) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? req1_ready : req0_ready;
        end
        chk("grant_wait", 64'(ok), 64'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        chk("result_wait", 64'(ok), 64'd1);
        got.id   = res_id;
        got.sum  = res_sum;
        got.cout = res_cout;
        got.ovf  = res_ovf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        exp_t        got;
        int          order[$];
        bit          p0, p1, ok;
        logic [31:0] hs;
        logic        hc, ho, hi;

        vecs[0] = '{0, 32'h0000_FFFF, 32'h0000_0001, 0, 32'h0001_0000, 32'h0001_0000, 0, 0};
        vecs[1] = '{1, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
        vecs[2] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1};
        vecs[3] = '{1, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1, 1};
        vecs[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1, 0};
        vecs[5] = '{1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'hACF1_3568, 32'hACF1_3568, 0, 0};
        vecs[6] = '{0, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 32'h0000_0000, 1, 0};
        vecs[7] = '{1, 32'h8000_0000, 32'h8000_0000, 0, 32'h0000_0000, 32'h8000_0000, 1, 1};

        #1;
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_res_sum", 64'(res_sum), 0);
        chk("rst_res_cout", 64'(res_cout), 0);
        chk("rst_res_ovf", 64'(res_ovf), 0);
        chk("rst_res_id", 64'(res_id), 0);
        chk("rst_add_a", 64'(add_a), 0);
        chk("rst_add_b", 64'(add_b), 0);
        chk("rst_add_cin", 64'(add_cin), 0);
        do_reset();

        // Latency and slice sequencing of a carry-crossing add
        @(posedge clk);
        #1 req0_a = 32'h0000_FFFF; req0_b = 32'h0000_0001; req0_sub = 1'b0; req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_ready0", 64'(req0_ready), 1);
        chk("t1_ready1_low", 64'(req1_ready), 0);
        @(posedge clk);
        #1 req0_valid = 1'b0; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t1_slice0_a", 64'(add_a), 64'h FFFF);
        chk("t1_slice0_b", 64'(add_b), 64'h0001);
        chk("t1_slice0_cin", 64'(add_cin), 0);
        chk("t1_res_valid_early", 64'(res_valid), 0);
        @(negedge clk);
        chk("t1_slice1_a", 64'(add_a), 0);
        chk("t1_slice1_b", 64'(add_b), 0);
        chk("t1_slice1_cin", 64'(add_cin), 1);
        @(negedge clk);
        chk("t1_res_valid_cycle3", 64'(res_valid), 1);
        chk("t1_res_sum", 64'(res_sum), 64'h0001_0000);
        chk("t1_add_idle", 64'(add_a), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_res_valid_drop", 64'(res_valid), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sub, got);
`ifdef ADD_SEQ_CTRL_SAT_EN
            chk($sformatf("vec%0d_sum", i), 64'(got.sum), 64'(vecs[i].sum_sat));
`else
            chk($sformatf("vec%0d_sum", i), 64'(got.sum), 64'(vecs[i].sum_wrap));
`endif
            chk($sformatf("vec%0d_cout", i), 64'(got.cout), 64'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 64'(got.ovf), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d_id", i), 64'(got.id), 64'(vecs[i].sel));
        end

        for (int i = 0; i < 6; i++)
            run_op(i[0], $urandom, $urandom, $urandom_range(1), got);

        // Contention: alternate grants, single-cycle ready pulses
        do_reset();
        @(posedge clk);
        #1 req0_a = 32'd10; req0_b = 32'd3; req0_sub = 1'b1; req0_valid = 1'b1;
        req1_a = 32'd20; req1_b = 32'd4; req1_sub = 1'b0; req1_valid = 1'b1;
        p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 60 && order.size() < 4; c++) begin
            @(negedge clk);
            chk("t4_single_pulse", 64'((req0_ready & p0) | (req1_ready & p1) | (req0_ready & req1_ready)), 0);
            if (req0_ready) order.push_back(0);
            if (req1_ready) order.push_back(1);
            p0 = req0_ready; p1 = req1_ready;
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t4_grant_count", 64'(order.size()), 4);
        for (int i = 0; i < order.size(); i++)
            chk($sformatf("t4_order%0d", i), 64'(order[i]), 64'(i % 2));

        // Back-pressure in DONE with a pending request
        res_ready = 1'b0;
        req0_a = 32'd1; req0_b = 32'd2; req0_sub = 1'b0; req0_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req0_ready;
        end
        chk("t5_grant", 64'(ok), 1);
        @(posedge clk);
        #1 req0_a = 32'd3; req0_b = 32'd4;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        chk("t5_res_valid", 64'(ok), 1);
        hs = res_sum; hc = res_cout; ho = res_ovf; hi = res_id;
        chk("t5_sum", 64'(hs), 3);
        repeat (5) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(res_valid), 1);
            chk("t5_hold_sum", 64'(res_sum), 64'(hs));
            chk("t5_hold_flags", 64'({res_cout, res_ovf, res_id}), 64'({hc, ho, hi}));
            chk("t5_no_accept", 64'(req0_ready), 0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_accept_first_idle", 64'(req0_ready), 1);
        chk("t5_valid_low", 64'(res_valid), 0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        chk("t5_second_sum", 64'(res_sum), 7);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN drops the operation and the rr pointer
        req0_a = 32'h1111_2222; req0_b = 32'h0000_3333; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 32'h0000_0009; req1_b = 32'h0000_0001; req1_sub = 1'b0; req1_valid = 1'b1;
        @(negedge clk);
        chk("t6_first_grant0", 64'(req0_ready), 1);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_slice1_a", 64'(add_a), 64'h1111);
        #1 resetn = 1'b0;
        sb.delete();
        #1;
        chk("t6_rst_valid", 64'(res_valid), 0);
        chk("t6_rst_add", 64'({add_a, add_b, add_cin}), 0);
        chk("t6_rst_sum", 64'(res_sum), 0);
        chk("t6_rst_id_cout", 64'({res_id, res_cout, res_ovf}), 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("t6_ptr_reset_g0", 64'(req0_ready), 1);
        chk("t6_ptr_reset_g1", 64'(req1_ready), 0);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        chk("t6_after_reset_valid", 64'(ok), 1);
        chk("t6_after_reset_sum", 64'(res_sum), 64'h1111_5555);
        chk("t6_after_reset_id", 64'(res_id), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
